// File: rtl/criptografia_gost.sv
// GOST 28147-89 ECB block cipher core: 64-bit block, 256-bit key, one Feistel round per clock.
module criptografia_gost (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [63:0]  data_i,
  input  logic [255:0] key_i,
  output logic [63:0]  data_o,
  output logic         busy_o,
  output logic         ready_o
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned RND_W   = 5;
  localparam int unsigned ROT     = 11;

  // Each row lists S-box outputs for inputs 0..F, input 0 in the top nibble.
  localparam logic [63:0] SBOX_ROWS [8] = '{
    64'h4A92D80E6B1C7F53,
    64'hEB4C6DFA23810759,
    64'h581DA342EFC7609B,
    64'h7DA1089FE46CB253,
    64'h6C715FD84A9E03B2,
    64'h4BA0721D36859CFE,
    64'hDB413F590AE7682C,
    64'h1FD057A4923E6B8C
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  logic [WORD_W-1:0]    n1_q, n1_d;
  logic [WORD_W-1:0]    n2_q, n2_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic                 enc_q, enc_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 key_rev;
  logic [2:0]           key_idx;
  logic [WORD_W-1:0]    subkey;
  logic [WORD_W-1:0]    sum;
  logic [WORD_W-1:0]    subst;
  logic [WORD_W-1:0]    f_val;
  logic [WORD_W-1:0]    mixed;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [3:0] x);
    logic [63:0] row;
    logic [5:0]  sh;
    row = SBOX_ROWS[box];
    sh  = 6'd60 - {x, 2'b00};
    return row[sh +: 4];
  endfunction

  // Round function: subkey schedule, modular add, S-box layer, rotate, mix into N2.
  always_comb begin
    key_rev = enc_q ? (rnd_q[4:3] == 2'b11) : (rnd_q[4:3] != 2'b00);
    key_idx = key_rev ? ~rnd_q[2:0] : rnd_q[2:0];
    subkey  = key_q[{key_idx, 5'b00000} +: WORD_W];
    sum     = n1_q + subkey;
    subst   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      subst[4*i +: 4] = sbox_lookup(3'(i), sum[4*i +: 4]);
    end
    f_val = {subst[WORD_W-ROT-1:0], subst[WORD_W-1:WORD_W-ROT]};
    mixed = n2_q ^ f_val;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    key_d   = key_q;
    enc_d   = enc_q;
    data_d  = data_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          rnd_d   = '0;
          n1_d    = data_i[31:0];
          n2_d    = data_i[63:32];
          key_d   = key_i;
          enc_d   = enc_dec;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == RND_W'(31)) begin
          // Final round keeps N1 in place (no swap) and publishes the block.
          n2_d    = mixed;
          data_d  = {mixed, n1_q};
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          n1_d = mixed;
          n2_d = n1_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      key_q   <= '0;
      enc_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      key_q   <= key_d;
      enc_q   <= enc_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign data_o  = data_q;
  assign busy_o  = busy_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_criptografia_gost.sv
// Self-checking bench for criptografia_gost: transaction-level cipher model plus directed scenarios.
module tb_criptografia_gost;

  localparam int unsigned SB [8][16] = '{
    '{4,10,9,2,13,8,0,14,6,11,1,12,7,15,5,3},
    '{14,11,4,12,6,13,15,10,2,3,8,1,0,7,5,9},
    '{5,8,1,13,10,3,4,2,14,15,12,7,6,0,9,11},
    '{7,13,10,1,0,8,9,15,14,4,6,12,11,2,5,3},
    '{6,12,7,1,5,15,13,8,4,10,9,14,0,3,11,2},
    '{4,11,10,0,7,2,1,13,3,6,8,5,9,12,15,14},
    '{13,11,4,1,3,15,5,9,0,10,14,7,6,8,2,12},
    '{1,15,13,0,5,7,10,4,9,2,3,14,6,11,8,12}
  };

  localparam logic [63:0]  PT  = 64'hA5A5A5A501234567;
  localparam logic [255:0] KEY = 256'hDEADBEEF89ABCDEF01234567DEADBEEFDEADBEEF89ABCDEF01234567DEADBEEF;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         enc_dec = 1'b0;
  logic [63:0]  data_i = '0;
  logic [255:0] key_i = '0;
  logic [63:0]  data_o;
  logic         busy_o;
  logic         ready_o;

  int n_cmp = 0;
  int n_err = 0;

  criptografia_gost dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .enc_dec (enc_dec),
    .data_i  (data_i),
    .key_i   (key_i),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .ready_o (ready_o)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] f_model(input logic [31:0] x);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 8; j++) s = s | (32'(SB[j][(x >> (4*j)) & 32'hF]) << (4*j));
    return (s << 11) | (s >> 21);
  endfunction

  function automatic logic [63:0] gost_model(input logic [63:0] blk, input logic [255:0] key, input logic enc);
    logic [31:0] n1, n2, t;
    logic [31:0] k [8];
    int ki;
    n1 = blk[31:0];
    n2 = blk[63:32];
    for (int i = 0; i < 8; i++) k[i] = key[32*i +: 32];
    for (int r = 0; r < 32; r++) begin
      if (enc) ki = (r < 24) ? (r % 8) : (31 - r);
      else     ki = (r < 8)  ? r       : (7 - (r % 8));
      t = n2 ^ f_model(n1 + k[ki]);
      if (r < 31) begin n2 = n1; n1 = t; end
      else n2 = t;
    end
    return {n2, n1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: accept, count 32 cycles, publish the model result.
  logic [63:0] exp_data = '0;
  logic        exp_busy = 1'b0;
  logic        exp_ready = 1'b0;
  logic [63:0] pending = '0;
  int          exp_cnt = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_data = '0; exp_busy = 1'b0; exp_ready = 1'b0; exp_cnt = 0;
    end else if (exp_busy) begin
      exp_cnt++;
      if (exp_cnt == 32) begin
        exp_busy = 1'b0; exp_ready = 1'b1; exp_data = pending;
      end
    end else if (start) begin
      pending = gost_model(data_i, key_i, enc_dec);
      exp_busy = 1'b1; exp_ready = 1'b0; exp_cnt = 0;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the reference.
  always @(negedge clock) begin
    check("cyc_busy",  64'(busy_o),  64'(exp_busy));
    check("cyc_ready", 64'(ready_o), 64'(exp_ready));
    check("cyc_data",  data_o, exp_data);
  end

  // Issue one operation at the current falling edge; return busy-cycle count at the edge ready appears.
  task automatic run_op(input logic [63:0] d, input logic [255:0] k, input logic e,
                        input int hold, input bit disturb, output int lat);
    bit done;
    lat = 0;
    done = 0;
    data_i = d; key_i = k; enc_dec = e; start = 1'b1;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      if (ready_o) begin
        done = 1;
      end else begin
        if (busy_o) lat++;
        start = (c < hold);
        if (disturb) begin
          start   = $urandom_range(0, 1) == 1;
          data_i  = {$urandom, $urandom};
          key_i   = {8{$urandom}};
          enc_dec = $urandom_range(0, 1) == 1;
        end
      end
    end
    start = 1'b0;
    check("op_completed", 64'(done), 64'd1);
  endtask

  logic [63:0] ct, blk_a, blk_b, ct_a;
  int lat;

  initial begin
    // Model pins: f(0) by hand, and model round trip.
    check("model_f0", 64'(f_model(32'h0)), 64'h33AF20EA);
    check("model_roundtrip", gost_model(gost_model(PT, KEY, 1'b1), KEY, 1'b0), PT);
    check("model_zero_roundtrip", gost_model(gost_model(64'h0, 256'h0, 1'b1), 256'h0, 1'b0), 64'h0);

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data", data_o, 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_ready", 64'(ready_o), 64'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_busy", 64'(busy_o), 64'h0);
    check("idle_ready", 64'(ready_o), 64'h0);

    // Encrypt with start held for 3 cycles.
    ct = gost_model(PT, KEY, 1'b1);
    run_op(PT, KEY, 1'b1, 3, 0, lat);
    check("enc_latency", 64'(lat), 64'd32);
    check("enc_result", data_o, ct);
    repeat (2) @(negedge clock);

    // Round trip back to the plaintext.
    run_op(ct, KEY, 1'b0, 1, 0, lat);
    check("dec_latency", 64'(lat), 64'd32);
    check("dec_result", data_o, 64'hA5A5A5A501234567);
    repeat (2) @(negedge clock);

    // Inputs churn during RUN must not disturb the result.
    run_op(PT, KEY, 1'b1, 1, 1, lat);
    check("busy_prot_latency", 64'(lat), 64'd32);
    check("busy_prot_result", data_o, ct);
    repeat (2) @(negedge clock);

    // Reset during round 10, then recover.
    data_i = 64'h0123456789ABCDEF; key_i = ~KEY; enc_dec = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_data", data_o, 64'h0);
    check("midrst_busy", 64'(busy_o), 64'h0);
    check("midrst_ready", 64'(ready_o), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(64'h0123456789ABCDEF, ~KEY, 1'b1, 1, 0, lat);
    check("post_rst_result", data_o, gost_model(64'h0123456789ABCDEF, ~KEY, 1'b1));
    check("post_rst_latency", 64'(lat), 64'd32);
    repeat (2) @(negedge clock);

    // Back-to-back: reissue start on the cycle ready rises.
    blk_a = 64'hFEDCBA9876543210;
    blk_b = 64'h0000000100000002;
    ct_a  = gost_model(blk_a, KEY, 1'b0);
    run_op(blk_a, KEY, 1'b0, 1, 0, lat);
    check("b2b_first", data_o, ct_a);
    run_op(blk_b, KEY, 1'b1, 1, 0, lat);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_second", data_o, gost_model(blk_b, KEY, 1'b1));
    repeat (3) @(negedge clock);
    check("done_hold_ready", 64'(ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
